// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants (20 ms / 500 ms / 200 ms at 50 MHz).
package btn_db_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_db_state_e;

    localparam int BTN_DB_STABLE_DEFAULT = 1_000_000;
    localparam int BTN_DB_HOLD_DEFAULT   = 25_000_000;
    localparam int BTN_DB_REPEAT_DEFAULT = 10_000_000;

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the pin side and the debouncer: raw key in,
// debounced level and press/release pulses out.
interface button_debouncer_if;

    logic key_i;
    logic key_o;
    logic press_o;
    logic release_o;

    // Pin / consumer side: drives the raw key, observes the cleaned outputs.
    modport master (
        output key_i,
        input  key_o,
        input  press_o,
        input  release_o
    );

    // Debouncer side.
    modport slave (
        input  key_i,
        output key_o,
        output press_o,
        output release_o
    );

endinterface

// File: rtl/button_debouncer_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset to 0 asynchronously; reusable for any board pin (e.g. reset button).
module btn_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Shift the raw pin through two flops to absorb metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw key, qualifies each level
// change over STABLE_CYCLES consecutive samples and emits a registered
// debounced level plus single-cycle press/release pulses.
// Optional auto-repeat of press pulses while held: define BTN_DB_AUTOREPEAT_EN.
module button_debouncer
    import btn_db_pkg::*;
#(
    parameter int STABLE_CYCLES = BTN_DB_STABLE_DEFAULT,
    parameter int HOLD_CYCLES   = BTN_DB_HOLD_DEFAULT,
    parameter int REPEAT_CYCLES = BTN_DB_REPEAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    button_debouncer_if.slave btn
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
    end

    logic          sync_q;
    btn_db_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          key_q, key_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_pulse;

    btn_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn.key_i),
        .q     (sync_q)
    );

    // Next-state and pulse decode; the counter is cleared on every state entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        key_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

`ifdef BTN_DB_AUTOREPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              repeating_q, repeating_d;
    logic              stay_held;

    // Hold timer: first threshold is HOLD_CYCLES, later ones REPEAT_CYCLES;
    // any exit from HELD (including to RELEASE_WAIT) restarts the first one.
    always_comb begin
        stay_held    = (state_q == HELD) && sync_q;
        hold_cnt_d   = '0;
        repeating_d  = 1'b0;
        repeat_pulse = 1'b0;
        if (stay_held) begin
            repeating_d = repeating_q;
            if (hold_cnt_q == (repeating_q ? REPEAT_LAST : HOLD_LAST)) begin
                repeat_pulse = 1'b1;
                repeating_d  = 1'b1;
                hold_cnt_d   = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            repeating_q <= repeating_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    // State, stability counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            press_q   <= press_d | repeat_pulse;
            release_q <= release_d;
        end
    end

    assign btn.key_o     = key_q;
    assign btn.press_o   = press_q;
    assign btn.release_o = release_q;

endmodule
